// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared definitions for the pipeline hazard controller: instruction type
//   class codes (mirroring const.v), forwarding select encodings, Tuse/Tnew
//   constants, the scoreboard entry layout and the decode/match helpers used
//   by hazard_unit and hazard_stage_reg.
package hazard_unit_pkg;

  // Instruction type class codes produced by the control decoder.
  localparam logic [4:0] TYPE_CALR  = 5'd0;
  localparam logic [4:0] TYPE_CALI  = 5'd1;
  localparam logic [4:0] TYPE_LUI   = 5'd2;
  localparam logic [4:0] TYPE_LOAD  = 5'd3;
  localparam logic [4:0] TYPE_STORE = 5'd4;
  localparam logic [4:0] TYPE_BEQ   = 5'd5;
  localparam logic [4:0] TYPE_JAL   = 5'd6;
  localparam logic [4:0] TYPE_JR    = 5'd7;
  localparam logic [4:0] TYPE_OTHER = 5'd31;

  // Operand source selects.
  //   D stage: GRF / E(pc8,EXT32) / M(AO,pc8) / W(WD)
  //   E stage: pipelined / - / M / W
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // Cycles until an operand is needed. TUSE_NONE exceeds every Tnew,
  // so an unused operand can never stall.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Cycles (counted from the E stage) until a result is available.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // One in-flight instruction as tracked by the scoreboard.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  function automatic logic [1:0] tuse_rs_of(input logic [4:0] t);
    case (t)
      TYPE_BEQ, TYPE_JR:                           return TUSE_0;
      TYPE_CALR, TYPE_CALI, TYPE_LOAD, TYPE_STORE: return TUSE_1;
      default:                                     return TUSE_NONE;
    endcase
  endfunction

  function automatic logic [1:0] tuse_rt_of(input logic [4:0] t);
    case (t)
      TYPE_BEQ:   return TUSE_0;
      TYPE_CALR:  return TUSE_1;
      TYPE_STORE: return TUSE_2;
      default:    return TUSE_NONE;
    endcase
  endfunction

  // Only these classes produce a GRF result the scoreboard must track.
  function automatic logic writes_grf(input logic [4:0] t);
    case (t)
      TYPE_CALR, TYPE_CALI, TYPE_LOAD, TYPE_LUI, TYPE_JAL: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_of(input logic [4:0] t);
    case (t)
      TYPE_CALR, TYPE_CALI: return TNEW_1;
      TYPE_LOAD:            return TNEW_2;
      default:              return TNEW_0;
    endcase
  endfunction

  // $0 is hardwired, so it never depends on an in-flight writer.
  function automatic logic reg_match(input logic [4:0] r, input sb_entry_t e);
    return (r != 5'd0) && (r == e.a3) && e.we;
  endfunction

  // Consumer needs the value before the producer can supply it.
  function automatic logic too_early(input logic [4:0] r, input logic [1:0] tuse,
                                     input sb_entry_t e);
    return reg_match(r, e) && (tuse < e.tnew);
  endfunction

  // Nearest matching stage decides; a not-yet-ready match selects GRF and
  // relies on the stall to hold the consumer until the value arrives.
  function automatic logic [1:0] d_fwd_sel(input logic [4:0] r, input sb_entry_t e,
                                           input sb_entry_t m, input sb_entry_t w);
    if (reg_match(r, e)) return (e.tnew == TNEW_0) ? FWD_E : FWD_GRF;
    if (reg_match(r, m)) return (m.tnew == TNEW_0) ? FWD_M : FWD_GRF;
    if (reg_match(r, w)) return FWD_W;
    return FWD_GRF;
  endfunction

  function automatic logic [1:0] e_fwd_sel(input logic [4:0] r, input sb_entry_t m,
                                           input sb_entry_t w);
    if (reg_match(r, m)) return (m.tnew == TNEW_0) ? FWD_M : FWD_GRF;
    if (reg_match(r, w)) return FWD_W;
    return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg
//   One scoreboard entry (E, M or W). Loads the upstream entry every cycle,
//   optionally counting its Tnew down by one (saturating at 0). reset or
//   bubble load an empty entry (we=0).
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous active-high clear
//     bubble in   load an empty entry instead of d
//     d      in   upstream entry
//     q      out  registered entry
module hazard_stage_reg
  import hazard_unit_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  sb_entry_t nxt;

  always_comb begin
    nxt = d;
    if (DEC_TNEW && (d.tnew != TNEW_0)) begin
      nxt.tnew = d.tnew - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= SB_BUBBLE;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard controller for the 5-stage MIPS pipeline. Tracks in-flight GRF
//   writers in an E/M/W scoreboard, raises stall when a D-stage operand is
//   needed before its producer can supply it, and drives the forwarding
//   selects for the D, E and M stage operand muxes.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     D_rs, D_rt          D-stage source register fields
//     D_type              D-stage instruction type class
//     D_GRFA3, D_GRFWE    D-stage destination register / write enable
//     stall               freeze PC and D register, bubble into E
//     D_fwd_rs, D_fwd_rt  D operand source (0 GRF, 1 E, 2 M, 3 W)
//     E_fwd_rs, E_fwd_rt  E operand source (0 pipelined, 2 M, 3 W)
//     M_fwd_rt            M store data source (0 pipelined, 1 W)
//     stall_cnt           number of stalled cycles since reset (wraps)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned TYPE_W      = 5,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             D_rs,
  input  logic [4:0]             D_rt,
  input  logic [TYPE_W-1:0]      D_type,
  input  logic [4:0]             D_GRFA3,
  input  logic                   D_GRFWE,
  output logic                   stall,
  output logic [1:0]             D_fwd_rs,
  output logic [1:0]             D_fwd_rt,
  output logic [1:0]             E_fwd_rs,
  output logic [1:0]             E_fwd_rt,
  output logic                   M_fwd_rt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0] d_code;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  sb_entry_t  d_entry;
  sb_entry_t  e_q;
  sb_entry_t  m_q;
  sb_entry_t  w_q;
  logic       unused_fields;

  assign d_code = 5'(D_type);

  // Decode the D-stage instruction into Tuse values and its E entry.
  always_comb begin
    tuse_rs_d    = tuse_rs_of(d_code);
    tuse_rt_d    = tuse_rt_of(d_code);
    d_entry      = SB_BUBBLE;
    d_entry.rs   = D_rs;
    d_entry.rt   = D_rt;
    d_entry.a3   = D_GRFA3;
    d_entry.we   = D_GRFWE & writes_grf(d_code);
    d_entry.tnew = tnew_of(d_code);
  end

  // E takes Tnew straight from decode; M and W count it down.
  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .d      (d_entry),
    .q      (e_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  // W always holds Tnew=0, so only E and M can cause a stall.
  always_comb begin
    stall = too_early(D_rs, tuse_rs_d, e_q) | too_early(D_rs, tuse_rs_d, m_q) |
            too_early(D_rt, tuse_rt_d, e_q) | too_early(D_rt, tuse_rt_d, m_q);
  end

  always_comb begin
    D_fwd_rs = d_fwd_sel(D_rs, e_q, m_q, w_q);
    D_fwd_rt = d_fwd_sel(D_rt, e_q, m_q, w_q);
    E_fwd_rs = e_fwd_sel(e_q.rs, m_q, w_q);
    E_fwd_rt = e_fwd_sel(e_q.rt, m_q, w_q);
    M_fwd_rt = reg_match(m_q.rt, w_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  // Entry fields carried for uniformity but not read at these stages.
  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew};

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Directed scenarios followed by randomized instruction streams, checked
//   against a reference model that tracks in-flight instructions by the
//   cycle their result becomes available.
module tb_hazard_unit;

  localparam int unsigned TW = 5;
  localparam int unsigned CW = 32;

  localparam int T_CALR  = 0;
  localparam int T_CALI  = 1;
  localparam int T_LUI   = 2;
  localparam int T_LOAD  = 3;
  localparam int T_STORE = 4;
  localparam int T_BEQ   = 5;
  localparam int T_JAL   = 6;
  localparam int T_JR    = 7;
  localparam int T_OTHER = 31;
  localparam int NO_USE  = 99;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    D_rs;
  logic [4:0]    D_rt;
  logic [TW-1:0] D_type;
  logic [4:0]    D_GRFA3;
  logic          D_GRFWE;
  logic          stall;
  logic [1:0]    D_fwd_rs;
  logic [1:0]    D_fwd_rt;
  logic [1:0]    E_fwd_rs;
  logic [1:0]    E_fwd_rt;
  logic          M_fwd_rt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.TYPE_W(TW), .STALL_CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_type    (D_type),
    .D_GRFA3   (D_GRFA3),
    .D_GRFWE   (D_GRFWE),
    .stall     (stall),
    .D_fwd_rs  (D_fwd_rs),
    .D_fwd_rt  (D_fwd_rt),
    .E_fwd_rs  (E_fwd_rs),
    .E_fwd_rt  (E_fwd_rt),
    .M_fwd_rt  (M_fwd_rt),
    .stall_cnt (stall_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // flight[0] is the instruction in E, [1] in M, [2] in W. Each remembers the
  // absolute cycle at which its result exists.
  typedef struct {
    int     rs;
    int     rt;
    int     a3;
    bit     writer;
    longint ready;
  } instr_t;

  instr_t flight[3];
  longint cyc;
  longint exp_cnt;
  bit     last_stall;
  int     type_pool[9] = '{T_CALR, T_CALI, T_LUI, T_LOAD, T_STORE, T_BEQ, T_JAL, T_JR, T_OTHER};

  function automatic instr_t empty_slot();
    instr_t b;
    b.rs = 0; b.rt = 0; b.a3 = 0; b.writer = 1'b0; b.ready = 0;
    return b;
  endfunction

  function automatic int remaining(int k);
    return (flight[k].ready > cyc) ? int'(flight[k].ready - cyc) : 0;
  endfunction

  function automatic bit produces(int r, int k);
    return (r != 0) && flight[k].writer && (flight[k].a3 == r);
  endfunction

  function automatic int use_lat(int ty, bit for_rt);
    case (ty)
      T_BEQ:          return 0;
      T_JR:           return for_rt ? NO_USE : 0;
      T_CALR:         return 1;
      T_CALI, T_LOAD: return for_rt ? NO_USE : 1;
      T_STORE:        return for_rt ? 2 : 1;
      default:        return NO_USE;
    endcase
  endfunction

  function automatic int result_lat(int ty);
    case (ty)
      T_CALR, T_CALI: return 1;
      T_LOAD:         return 2;
      T_LUI, T_JAL:   return 0;
      default:        return -1;
    endcase
  endfunction

  function automatic bit must_wait(int r, int ty, bit for_rt);
    for (int k = 0; k < 2; k++)
      if (produces(r, k) && (remaining(k) > use_lat(ty, for_rt))) return 1'b1;
    return 1'b0;
  endfunction

  // Source code of stage k is k+1 (E=1, M=2, W=3); first producer found wins.
  function automatic int src_from(int r, int first);
    for (int k = first; k < 3; k++)
      if (produces(r, k)) return (remaining(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic step(input int rs, input int rt, input int ty, input int a3,
                      input bit we, input bit rst);
    bit exp_stall;
    @(negedge clk);
    D_rs    = 5'(rs);
    D_rt    = 5'(rt);
    D_type  = TW'(ty);
    D_GRFA3 = 5'(a3);
    D_GRFWE = we;
    reset   = rst;
    #1;
    exp_stall = must_wait(rs, ty, 1'b0) || must_wait(rt, ty, 1'b1);
    check("stall",     32'(stall),     32'(exp_stall));
    check("D_fwd_rs",  32'(D_fwd_rs),  32'(src_from(rs, 0)));
    check("D_fwd_rt",  32'(D_fwd_rt),  32'(src_from(rt, 0)));
    check("E_fwd_rs",  32'(E_fwd_rs),  32'(src_from(flight[0].rs, 1)));
    check("E_fwd_rt",  32'(E_fwd_rt),  32'(src_from(flight[0].rt, 1)));
    check("M_fwd_rt",  32'(M_fwd_rt),  32'(produces(flight[1].rt, 2)));
    check("stall_cnt", stall_cnt,      32'(exp_cnt));
    if (rst) begin
      for (int k = 0; k < 3; k++) flight[k] = empty_slot();
      exp_cnt = 0;
    end else begin
      if (exp_stall) exp_cnt++;
      flight[2] = flight[1];
      flight[1] = flight[0];
      if (exp_stall) begin
        flight[0] = empty_slot();
      end else begin
        flight[0].rs     = rs;
        flight[0].rt     = rt;
        flight[0].a3     = a3;
        flight[0].writer = we && (result_lat(ty) >= 0);
        flight[0].ready  = cyc + 1 + ((result_lat(ty) > 0) ? result_lat(ty) : 0);
      end
    end
    last_stall = exp_stall;
    cyc++;
  endtask

  task automatic idle(input bit rst);
    step(0, 0, T_OTHER, 0, 1'b0, rst);
  endtask

  initial begin
    int cur_rs, cur_rt, cur_ty, cur_a3;
    bit cur_we;
    reset   = 1'b1;
    D_rs    = '0;
    D_rt    = '0;
    D_type  = TW'(T_OTHER);
    D_GRFA3 = '0;
    D_GRFWE = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) flight[k] = empty_slot();
    cyc = 0; exp_cnt = 0; last_stall = 1'b0;

    // Reset state.
    idle(1'b0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_cnt",   stall_cnt,  32'd0);

    // lw $1 ; add $2,$1,$1 : one-cycle load-use stall, W forwarding in E.
    idle(1'b1);
    step(0, 0, T_LOAD, 1, 1'b1, 1'b0);
    step(1, 1, T_CALR, 2, 1'b1, 1'b0); check("lu_stall_c1", 32'(stall), 32'd1);
    step(1, 1, T_CALR, 2, 1'b1, 1'b0); check("lu_stall_c2", 32'(stall), 32'd0);
    idle(1'b0);
    check("lu_efwd_rs", 32'(E_fwd_rs), 32'd3);
    check("lu_efwd_rt", 32'(E_fwd_rt), 32'd3);
    check("lu_cnt",     stall_cnt,     32'd1);

    // lw $1 ; beq $1,$0 : two stall cycles, then W forwarding in D.
    idle(1'b1);
    step(0, 0, T_LOAD, 1, 1'b1, 1'b0);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b0); check("lb_stall_c1", 32'(stall), 32'd1);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b0); check("lb_stall_c2", 32'(stall), 32'd1);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b0); check("lb_stall_c3", 32'(stall), 32'd0);
    check("lb_dfwd_rs", 32'(D_fwd_rs), 32'd3);
    check("lb_cnt",     stall_cnt,     32'd2);

    // ori $3 ; sw $3,0($0) : no stall, store data forwarded from M in E.
    idle(1'b1);
    step(0, 0, T_CALI, 3, 1'b1, 1'b0);
    step(0, 3, T_STORE, 0, 1'b0, 1'b0); check("os_stall", 32'(stall), 32'd0);
    idle(1'b0); check("os_efwd_rt", 32'(E_fwd_rt), 32'd2);
    idle(1'b0);

    // jal ; jr $31 : no stall, pc8 forwarded from E.
    idle(1'b1);
    step(0, 0, T_JAL, 31, 1'b1, 1'b0);
    step(31, 0, T_JR, 0, 1'b0, 1'b0);
    check("jj_stall",   32'(stall),    32'd0);
    check("jj_dfwd_rs", 32'(D_fwd_rs), 32'd1);

    // add $0,$1,$1 ; beq $0,$0 : $0 never stalls or forwards.
    idle(1'b1);
    step(1, 1, T_CALR, 0, 1'b1, 1'b0);
    step(0, 0, T_BEQ, 0, 1'b0, 1'b0);
    check("z_stall",   32'(stall),    32'd0);
    check("z_dfwd_rs", 32'(D_fwd_rs), 32'd0);
    check("z_dfwd_rt", 32'(D_fwd_rt), 32'd0);

    // Reset during the second beq stall cycle clears everything.
    idle(1'b1);
    step(0, 0, T_LOAD, 1, 1'b1, 1'b0);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b0);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b1); check("rs_stall_c2", 32'(stall), 32'd1);
    step(1, 0, T_BEQ, 0, 1'b0, 1'b0);
    check("rs_stall",   32'(stall),    32'd0);
    check("rs_dfwd_rs", 32'(D_fwd_rs), 32'd0);
    check("rs_efwd_rs", 32'(E_fwd_rs), 32'd0);
    check("rs_mfwd_rt", 32'(M_fwd_rt), 32'd0);
    check("rs_cnt",     stall_cnt,     32'd0);

    // Random instruction streams; a stalled instruction is held in D.
    cur_rs = 0; cur_rt = 0; cur_ty = T_OTHER; cur_a3 = 0; cur_we = 1'b0;
    last_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      if (!last_stall) begin
        cur_ty = type_pool[$urandom_range(8)];
        cur_rs = ($urandom_range(7) == 0) ? 31 : int'($urandom_range(3));
        cur_rt = ($urandom_range(7) == 0) ? 31 : int'($urandom_range(3));
        cur_a3 = (cur_ty == T_JAL) ? 31 : int'($urandom_range(3));
        cur_we = ($urandom_range(7) != 0);
      end
      rst = ($urandom_range(63) == 0);
      step(cur_rs, cur_rt, cur_ty, cur_a3, cur_we, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
